sim_monitor: RTL and testbench

SIM_MONITOR -- requirements
Module: sim_monitor

---
 rtl/sim_monitor.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sim_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_monitor.sv
// sim_monitor
// -----------
// Simulation monitor for a core under test. Counts core cycles and up to
// NUM_EV event strobes while the core is enabled, captures the value the core
// writes to the "tohost" location, and runs a watchdog that ends the run if the
// core never reports. All counters, status and the captured code are readable
// through a simple command bus.
//
// Ports
//   clk_i        single clock, all state changes on its rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         core out of reset; counting is enabled while high
//   ev_i         per-cycle event strobes, bit k bumps event counter k
//   cmd_valid_i  bus command valid (one command per cycle, no back-pressure)
//   cmd_we_i     1 = write, 0 = read
//   cmd_addr_i   byte address; bit 28 selects tohost, bits [7:2] the register
//   cmd_wdata_i  write data
//   rdata_o      read data, valid with rvalid_o
//   rvalid_o     high for exactly one cycle, one cycle after each read command
//   done_o       run finished (pass, fail or timeout)
//   pass_o       finished with PASS_CODE
//   timeout_o    finished by the watchdog
//   code_o       captured tohost value
//   ovf_o        sticky overflow flags; bit 0 = cycle counter, bit k+1 = event k
//
// Bus handshake: a command is taken in every cycle cmd_valid_i is high at the
// rising edge; there is no ready. A read taken at edge n presents rdata_o with
// rvalid_o high after edge n and drops rvalid_o after edge n+1 unless another
// read was taken there.
//
// Register map (index = cmd_addr_i[7:2], cmd_addr_i[28] = 0)
//   0/1         cycle counter low/high word
//   2+2k/3+2k   event counter k low/high word
//   62          {27'b0, state[1:0], timeout, pass, done}
//   63          read: ovf zero-extended; write: clear counters and ovf
//   others      read 0, writes ignored

module sim_monitor #(
  parameter int unsigned NUM_EV    = 4,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned TIMEOUT   = 1500,
  parameter logic [31:0] PASS_CODE = 32'h777
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NUM_EV-1:0] ev_i,
  input  logic              cmd_valid_i,
  input  logic              cmd_we_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [31:0]       code_o,
  output logic [NUM_EV:0]   ovf_o
);

  // State encoding is visible on the bus (register 62), keep it stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ev_cnt_q [NUM_EV];
  logic [CNT_W-1:0]  ev_cnt_d [NUM_EV];
  logic [NUM_EV:0]   ovf_q, ovf_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       code_q, code_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [5:0] idx;
  logic       is_read;
  logic       is_tohost;
  logic       is_clear;
  logic       live;
  logic       count_en;
  logic       wd_hit;

  assign idx       = cmd_addr_i[7:2];
  assign is_read   = cmd_valid_i & ~cmd_we_i & ~cmd_addr_i[28];
  assign is_tohost = cmd_valid_i &  cmd_we_i &  cmd_addr_i[28];
  assign is_clear  = cmd_valid_i &  cmd_we_i & ~cmd_addr_i[28] & (idx == 6'd63);

  // Everything except reads freezes once the run is over.
  assign live     = (state_q != ST_DONE);

  // A cycle counts when the core is enabled at the edge, so the first edge
  // with en_i high (the IDLE->RUN edge) is already a counting cycle.
  assign count_en = live & en_i;

  // Watchdog fires on the edge where its count reaches TIMEOUT.
  assign wd_hit   = live && (TIMEOUT != 0) && ((wd_q + 32'd1) == TIMEOUT);

  // Remaining address bits carry no meaning for this block.
  logic unused_addr;
  assign unused_addr = ^{cmd_addr_i[31:29], cmd_addr_i[27:8], cmd_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Increment with overflow flag in the MSB. From all-ones the counter either
  // wraps to zero or holds, depending on SATURATE; the flag is raised in both.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (&v) begin
      r = {1'b1, (SATURATE != 0) ? v : {CNT_W{1'b0}}};
    end else begin
      r = {1'b0, v + 1'b1};
    end
    return r;
  endfunction

  // Counters narrower than 64 bits read zero-extended.
  function automatic logic [63:0] ext64(input logic [CNT_W-1:0] v);
    logic [63:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Counters and watchdog next state
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [CNT_W:0] b;
    cyc_d = cyc_q;
    ovf_d = ovf_q;
    wd_d  = wd_q;
    b     = '0;
    for (int k = 0; k < NUM_EV; k++) begin
      ev_cnt_d[k] = ev_cnt_q[k];
    end

    if (live && (TIMEOUT != 0)) begin
      wd_d = wd_q + 32'd1;
    end

    if (count_en) begin
      b     = bump(cyc_q);
      cyc_d = b[CNT_W-1:0];
      if (b[CNT_W]) ovf_d[0] = 1'b1;
      for (int k = 0; k < NUM_EV; k++) begin
        if (ev_i[k]) begin
          b           = bump(ev_cnt_q[k]);
          ev_cnt_d[k] = b[CNT_W-1:0];
          if (b[CNT_W]) ovf_d[k+1] = 1'b1;
        end
      end
    end

    // Clear overrides any increment in the same cycle.
    if (live && is_clear) begin
      cyc_d = '0;
      ovf_d = '0;
      for (int k = 0; k < NUM_EV; k++) begin
        ev_cnt_d[k] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run control next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        // Tohost is checked before the watchdog so it wins a same-cycle tie.
        if (count_en && is_tohost) begin
          code_d  = cmd_wdata_i;
          done_d  = 1'b1;
          pass_d  = (cmd_wdata_i == PASS_CODE);
          state_d = ST_DONE;
        end else if (wd_hit) begin
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = en_i ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux, served in every state
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [63:0] w;
    logic [31:0] rd;
    w  = ext64(cyc_q);
    rd = '0;
    case (idx)
      6'd0:  rd = w[31:0];
      6'd1:  rd = w[63:32];
      6'd62: rd = {27'b0, state_q, tmo_q, pass_q, done_q};
      6'd63: rd[NUM_EV:0] = ovf_q;
      default: begin
        for (int k = 0; k < NUM_EV; k++) begin
          w = ext64(ev_cnt_q[k]);
          if (idx == 6'(2 + 2 * k)) rd = w[31:0];
          if (idx == 6'(3 + 2 * k)) rd = w[63:32];
        end
      end
    endcase
    rdata_d  = is_read ? rd : 32'h0;
    rvalid_d = is_read;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      ovf_q    <= '0;
      wd_q     <= '0;
      code_q   <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int k = 0; k < NUM_EV; k++) begin
        ev_cnt_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      ovf_q    <= ovf_d;
      wd_q     <= wd_d;
      code_q   <= code_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int k = 0; k < NUM_EV; k++) begin
        ev_cnt_q[k] <= ev_cnt_d[k];
      end
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = tmo_q;
  assign code_o    = code_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_sim_monitor.sv
// Bench for sim_monitor. Four instances share one stimulus stream:
//   m : default parameters
//   w : TIMEOUT = 50
//   a : CNT_W = 8, SATURATE = 0, NUM_EV = 2
//   b : CNT_W = 8, SATURATE = 1, NUM_EV = 2
// Inputs change 1 ns after a rising edge; outputs are checked there too.

module tb_sim_monitor;

  localparam logic [31:0] TOHOST = 32'h1000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [3:0]  ev;
  logic        cmd_valid;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic [31:0] rdata_m, rdata_w, rdata_a, rdata_b;
  logic        rvalid_m, rvalid_w, rvalid_a, rvalid_b;
  logic        done_m, done_w, done_a, done_b;
  logic        pass_m, pass_w, pass_a, pass_b;
  logic        tmo_m, tmo_w, tmo_a, tmo_b;
  logic [31:0] code_m, code_w, code_a, code_b;
  logic [4:0]  ovf_m, ovf_w;
  logic [2:0]  ovf_a, ovf_b;

  sim_monitor u_m (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ev_i(ev),
    .cmd_valid_i(cmd_valid), .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rdata_o(rdata_m), .rvalid_o(rvalid_m), .done_o(done_m), .pass_o(pass_m),
    .timeout_o(tmo_m), .code_o(code_m), .ovf_o(ovf_m)
  );

  sim_monitor #(.TIMEOUT(50)) u_w (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ev_i(ev),
    .cmd_valid_i(cmd_valid), .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rdata_o(rdata_w), .rvalid_o(rvalid_w), .done_o(done_w), .pass_o(pass_w),
    .timeout_o(tmo_w), .code_o(code_w), .ovf_o(ovf_w)
  );

  sim_monitor #(.NUM_EV(2), .CNT_W(8), .SATURATE(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ev_i(ev[1:0]),
    .cmd_valid_i(cmd_valid), .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rdata_o(rdata_a), .rvalid_o(rvalid_a), .done_o(done_a), .pass_o(pass_a),
    .timeout_o(tmo_a), .code_o(code_a), .ovf_o(ovf_a)
  );

  sim_monitor #(.NUM_EV(2), .CNT_W(8), .SATURATE(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ev_i(ev[1:0]),
    .cmd_valid_i(cmd_valid), .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rdata_o(rdata_b), .rvalid_o(rvalid_b), .done_o(done_b), .pass_o(pass_b),
    .timeout_o(tmo_b), .code_o(code_b), .ovf_o(ovf_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    ev        = '0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick(1);
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
  endtask

  // sel: 0 = m, 1 = w, 2 = a, 3 = b
  task automatic rd(input string tag, input int sel, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    logic        v;
    exp_q.push_back(exp);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'(idx) << 2;
    tick(1);
    cmd_valid = 1'b0;
    case (sel)
      0:       begin got = rdata_m; v = rvalid_m; end
      1:       begin got = rdata_w; v = rvalid_w; end
      2:       begin got = rdata_a; v = rvalid_a; end
      default: begin got = rdata_b; v = rvalid_b; end
    endcase
    check({tag, "_rvalid"}, {63'd0, v}, 64'd1);
    check(tag, {32'd0, got}, {32'd0, exp_q.pop_front()});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    do_reset();

    // Reset state
    check("rst_done", {63'd0, done_m}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid_m}, 64'd0);
    check("rst_code", {32'd0, code_m}, 64'd0);
    check("rst_ovf", {59'd0, ovf_m}, 64'd0);
    rd("rst_status", 0, 62, 32'h0);

    // 10 counting cycles, event 0 strobed in 3 of them
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      ev = (c == 2 || c == 5 || c == 7) ? 4'b0001 : 4'b0000;
      tick(1);
    end
    ev = '0;
    en = 1'b0;
    rd("cnt10_cyc_lo", 0, 0, 32'd10);
    tick(1);
    check("rvalid_one_cycle", {63'd0, rvalid_m}, 64'd0);
    rd("cnt10_cyc_hi", 0, 1, 32'd0);
    rd("cnt10_ev0", 0, 2, 32'd3);
    rd("cnt10_ev1", 0, 4, 32'd0);
    rd("cnt10_status_idle", 0, 62, 32'h0);

    // Ignored write, then clear while event 1 strobes
    do_reset();
    en = 1'b1;
    ev = 4'b0010;
    tick(5);
    en = 1'b0;
    ev = '0;
    rd("ev1_before", 0, 4, 32'd5);
    bus_write(32'h0000_0000, 32'hdead_beef);
    rd("ev1_after_ignored_wr", 0, 4, 32'd5);
    rd("cyc_after_ignored_wr", 0, 0, 32'd5);
    en = 1'b1;
    ev = 4'b0010;
    bus_write(32'h0000_00FC, 32'h0);
    en = 1'b0;
    ev = '0;
    rd("ev1_cleared", 0, 4, 32'd0);
    rd("cyc_cleared", 0, 0, 32'd0);
    check("ovf_cleared", {59'd0, ovf_m}, 64'd0);

    // Pass: tohost 0x777 on the 20th counting cycle
    do_reset();
    en = 1'b1;
    tick(19);
    bus_write(TOHOST, 32'h777);
    check("pass_done", {63'd0, done_m}, 64'd1);
    check("pass_pass", {63'd0, pass_m}, 64'd1);
    check("pass_tmo", {63'd0, tmo_m}, 64'd0);
    check("pass_code", {32'd0, code_m}, 64'h777);
    ev = 4'hF;
    tick(5);
    ev = '0;
    en = 1'b0;
    rd("pass_cyc_frozen", 0, 0, 32'd20);
    rd("pass_ev0_frozen", 0, 2, 32'd0);
    bus_write(32'h0000_00FC, 32'h0);
    rd("pass_clear_ignored", 0, 0, 32'd20);
    rd("pass_status", 0, 62, 32'h13);

    // Fail code, then reset out of DONE
    do_reset();
    en = 1'b1;
    tick(3);
    bus_write(TOHOST, 32'h5);
    en = 1'b0;
    check("fail_done", {63'd0, done_m}, 64'd1);
    check("fail_pass", {63'd0, pass_m}, 64'd0);
    check("fail_code", {32'd0, code_m}, 64'h5);
    rd("fail_cyc", 0, 0, 32'd4);
    rd("fail_status", 0, 62, 32'h11);
    do_reset();
    check("rst_from_done", {63'd0, done_m}, 64'd0);
    check("rst_from_done_code", {32'd0, code_m}, 64'd0);
    rd("rst_from_done_status", 0, 62, 32'h0);

    // Reset asserted while read data is being presented
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0;
    tick(1);
    cmd_valid = 1'b0;
    check("rv_before_rst", {63'd0, rvalid_m}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rv_dropped_by_rst", {63'd0, rvalid_m}, 64'd0);

    // Watchdog expiry with en_i low
    do_reset();
    tick(49);
    check("wd_not_yet", {63'd0, done_w}, 64'd0);
    tick(1);
    check("wd_done", {63'd0, done_w}, 64'd1);
    check("wd_tmo", {63'd0, tmo_w}, 64'd1);
    check("wd_code", {32'd0, code_w}, 64'd0);
    check("wd_pass", {63'd0, pass_w}, 64'd0);
    rd("wd_status", 1, 62, 32'h15);

    // Tohost on the same edge as watchdog expiry
    do_reset();
    en = 1'b1;
    tick(49);
    bus_write(TOHOST, 32'h777);
    en = 1'b0;
    check("tie_done", {63'd0, done_w}, 64'd1);
    check("tie_tmo", {63'd0, tmo_w}, 64'd0);
    check("tie_pass", {63'd0, pass_w}, 64'd1);
    check("tie_code", {32'd0, code_w}, 64'h777);

    // 8-bit counters over 300 counting cycles, event 0 every cycle
    do_reset();
    en = 1'b1;
    ev = 4'b0001;
    tick(300);
    en = 1'b0;
    ev = '0;
    rd("wrap_cyc", 2, 0, 32'd44);
    rd("wrap_cyc_hi", 2, 1, 32'd0);
    rd("wrap_ev0", 2, 2, 32'd44);
    rd("wrap_ovf_reg", 2, 63, 32'd3);
    check("wrap_ovf", {61'd0, ovf_a}, 64'd3);
    rd("sat_cyc", 3, 0, 32'd255);
    rd("sat_ev0", 3, 2, 32'd255);
    check("sat_ovf", {61'd0, ovf_b}, 64'd3);
    rd("wide_cyc", 0, 0, 32'd300);
    rd("wide_cyc_hi", 0, 1, 32'd0);
    check("wide_ovf", {59'd0, ovf_m}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1);
  end

endmodule
